// File: rtl/clint_pkg.sv
// Shared constants for the core-local interrupt sequencer: CSR addresses,
// trap-related instruction encodings, cause codes and FSM state encodings.
package clint_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;

  localparam logic [2:0] ST_IDLE           = 3'd0;
  localparam logic [2:0] ST_W_MEPC         = 3'd1;
  localparam logic [2:0] ST_W_MSTATUS      = 3'd2;
  localparam logic [2:0] ST_W_MCAUSE       = 3'd3;
  localparam logic [2:0] ST_ASSERT         = 3'd4;
  localparam logic [2:0] ST_W_MSTATUS_MRET = 3'd5;
  localparam logic [2:0] ST_ASSERT_MRET    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE           = ST_IDLE,
    S_W_MEPC         = ST_W_MEPC,
    S_W_MSTATUS      = ST_W_MSTATUS,
    S_W_MCAUSE       = ST_W_MCAUSE,
    S_ASSERT         = ST_ASSERT,
    S_W_MSTATUS_MRET = ST_W_MSTATUS_MRET,
    S_ASSERT_MRET    = ST_ASSERT_MRET
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_SYNC,
    REQ_MRET,
    REQ_ASYNC
  } req_e;

  // Trap entry: MPIE <= MIE, MIE <= 0.
  function automatic logic [31:0] mstatus_trap(input logic [31:0] m);
    return {m[31:8], m[3], m[6:4], 1'b0, m[2:0]};
  endfunction

  // Trap return: MPIE <= 1, MIE <= MPIE.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] m);
    return {m[31:8], 1'b1, m[6:4], m[7], m[2:0]};
  endfunction

endpackage

// File: rtl/clint_if.sv
// Bundle of the sequencer's pipeline-side inputs, CSR write port and
// redirect outputs; slave is the sequencer, master is its environment.
interface clint_if #(
  parameter int INT_W = 8
);
  logic [INT_W-1:0] int_flag_i;
  logic [31:0]      inst_i;
  logic [31:0]      inst_addr_i;
  logic             jump_flag_i;
  logic [31:0]      jump_addr_i;
  logic             global_int_en_i;
  logic [31:0]      csr_mtvec_i;
  logic [31:0]      csr_mepc_i;
  logic [31:0]      csr_mstatus_i;
  logic             we_o;
  logic [31:0]      waddr_o;
  logic [31:0]      raddr_o;
  logic [31:0]      data_o;
  logic             hold_flag_o;
  logic             int_assert_o;
  logic [31:0]      int_addr_o;

  modport slave (
    input  int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i,
           global_int_en_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    output we_o, waddr_o, raddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o
  );

  modport master (
    output int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i,
           global_int_en_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    input  we_o, waddr_o, raddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o
  );
endinterface

// File: rtl/clint.sv
// Core-local interrupt/exception sequencer: stalls the pipeline, writes
// mepc/mstatus/mcause one per cycle, then strobes a redirect.
module clint
  import clint_pkg::*;
#(
  parameter int          INT_W       = 8,
  parameter logic [31:0] ASYNC_CAUSE = 32'h8000_0004
) (
  input  logic clk,
  input  logic rst,
  clint_if.slave bus
);

  state_e           state_q;
  logic [31:0]      cause_q;
  logic             we_q;
  logic [11:0]      waddr_q;
  logic [31:0]      data_q;
  logic             int_assert_q;
  logic [31:0]      int_addr_q;

  logic [INT_W-1:0] int_flag;
  req_e             req;
  logic [31:0]      epc_d;
  logic [31:0]      cause_d;

  assign int_flag = bus.int_flag_i;

  // Requests are only recognised in IDLE; a level interrupt stays pending.
  always_comb begin
    req = REQ_NONE;
    if (state_q == S_IDLE) begin
      if (bus.inst_i == INST_ECALL || bus.inst_i == INST_EBREAK)
        req = REQ_SYNC;
      else if (bus.inst_i == INST_MRET)
        req = REQ_MRET;
      else if ((|int_flag) && bus.global_int_en_i)
        req = REQ_ASYNC;
    end
  end

  // An interrupt taken while ex redirects must return to the redirect target.
  always_comb begin
    epc_d   = bus.inst_addr_i;
    cause_d = (bus.inst_i == INST_EBREAK) ? CAUSE_EBREAK : CAUSE_ECALL;
    if (req == REQ_ASYNC) begin
      cause_d = ASYNC_CAUSE;
      if (bus.jump_flag_i)
        epc_d = bus.jump_addr_i;
    end
  end

  // Outputs are loaded on entry to the state they belong to; the epc is
  // latched straight into the data register on the way into W_MEPC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cause_q      <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      data_q       <= '0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
    end else begin
      we_q         <= 1'b0;
      waddr_q      <= '0;
      data_q       <= '0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
      case (state_q)
        S_IDLE: begin
          case (req)
            REQ_SYNC, REQ_ASYNC: begin
              state_q <= S_W_MEPC;
              cause_q <= cause_d;
              we_q    <= 1'b1;
              waddr_q <= CSR_MEPC;
              data_q  <= epc_d;
            end
            REQ_MRET: begin
              state_q <= S_W_MSTATUS_MRET;
              we_q    <= 1'b1;
              waddr_q <= CSR_MSTATUS;
              data_q  <= mstatus_mret(bus.csr_mstatus_i);
            end
            default: state_q <= S_IDLE;
          endcase
        end
        S_W_MEPC: begin
          state_q <= S_W_MSTATUS;
          we_q    <= 1'b1;
          waddr_q <= CSR_MSTATUS;
          data_q  <= mstatus_trap(bus.csr_mstatus_i);
        end
        S_W_MSTATUS: begin
          state_q <= S_W_MCAUSE;
          we_q    <= 1'b1;
          waddr_q <= CSR_MCAUSE;
          data_q  <= cause_q;
        end
        S_W_MCAUSE: begin
          state_q      <= S_ASSERT;
          int_assert_q <= 1'b1;
          int_addr_q   <= bus.csr_mtvec_i;
        end
        S_W_MSTATUS_MRET: begin
          state_q      <= S_ASSERT_MRET;
          int_assert_q <= 1'b1;
          int_addr_q   <= bus.csr_mepc_i;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.we_o         = we_q;
  assign bus.waddr_o      = {20'd0, waddr_q};
  assign bus.raddr_o      = '0;
  assign bus.data_o       = data_q;
  assign bus.int_assert_o = int_assert_q;
  assign bus.int_addr_o   = int_addr_q;
  assign bus.hold_flag_o  = (state_q != S_IDLE) || (req != REQ_NONE);

endmodule

// File: doc/clint.md
Name: clint

Overview:
- Core-local interrupt/exception sequencer, directly upstream of the CSR register file. It drives that block's clint write port.
- It detects three kinds of event:
  - synchronous traps (ecall, ebreak) from the decode-stage instruction;
  - asynchronous interrupts from the external interrupt lines;
  - mret.
- For each event it stalls the pipeline, performs the required mepc/mstatus/mcause writes one per cycle, then issues a redirect (int_assert_o/int_addr_o) to the pipeline control.

Parameters:
- INT_W, 8, width of the external interrupt request vector.
- ASYNC_CAUSE, 32'h80000004, value written to mcause for any asynchronous interrupt.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- int_flag_i  in  INT_W  interrupt request lines, level, OR-reduced
- inst_i  in  32  instruction currently in decode
- inst_addr_i  in  32  PC of inst_i
- jump_flag_i  in  1  ex is redirecting this cycle
- jump_addr_i  in  32  ex redirect target
- global_int_en_i  in  1  mstatus.MIE from CSR file
- csr_mtvec_i  in  32  current mtvec
- csr_mepc_i  in  32  current mepc
- csr_mstatus_i  in  32  current mstatus
- we_o  out  1  CSR write enable
- waddr_o  out  32  CSR write address (bits 11:0 significant, upper bits 0)
- raddr_o  out  32  CSR read address; reserved, constant 0
- data_o  out  32  CSR write data
- hold_flag_o  out  1  pipeline stall request
- int_assert_o  out  1  one-cycle redirect strobe
- int_addr_o  out  32  redirect target

Behaviour:
- Reset: state IDLE; we_o, waddr_o, data_o, int_assert_o, int_addr_o and latched cause/epc all 0. hold_flag_o is 0 once state is IDLE and no request is present.
- Request detection (combinational, IDLE only). Priority order:
  1. SYNC: inst_i==32'h00000073 (ecall, cause 11) or 32'h00100073 (ebreak, cause 3).
  2. MRET: inst_i==32'h30200073.
  3. ASYNC: |int_flag_i && global_int_en_i.
- Requests arriving while state!=IDLE are ignored. ASYNC remains pending because it is level-sensitive.
- hold_flag_o = (state!=IDLE) || request detected. It is combinational and asserted in the detection cycle.
- Latching in the detection cycle:
  - SYNC: epc=inst_addr_i.
  - ASYNC: epc = jump_flag_i ? jump_addr_i : inst_addr_i.
  - Cause register is loaded at the same time.
- Trap sequence (SYNC/ASYNC). States IDLE -> W_MEPC -> W_MSTATUS -> W_MCAUSE -> ASSERT -> IDLE. Registered outputs, one per cycle:
  - W_MEPC: we_o=1, waddr_o=0x341, data_o=epc.
  - W_MSTATUS: we_o=1, waddr_o=0x300, data_o={mstatus[31:8], mstatus[3], mstatus[6:4], 1'b0, mstatus[2:0]}. This gives MPIE<=MIE and MIE<=0.
  - W_MCAUSE: we_o=1, waddr_o=0x342, data_o=cause.
  - ASSERT: we_o=0, int_assert_o=1, int_addr_o=csr_mtvec_i.
- MRET sequence: IDLE -> W_MSTATUS_MRET -> ASSERT_MRET -> IDLE.
  - W_MSTATUS_MRET: we_o=1, waddr_o=0x300, data_o={mstatus[31:8], 1'b1, mstatus[6:4], mstatus[7], mstatus[2:0]}.
  - ASSERT_MRET: int_assert_o=1, int_addr_o=csr_mepc_i.
- Latency: detection cycle plus 4 cycles (trap) or plus 2 cycles (mret) to the redirect strobe. hold_flag_o stays high through the ASSERT state inclusive.
- we_o and int_assert_o are single-cycle per state; in all other states they are 0. waddr_o and data_o return to 0 in IDLE.
- The CSR file gives ex-port writes priority. Ex is held from the detection cycle, so no ex CSR write may coincide with our writes.
- Reset mid-sequence: next cycle is IDLE with all outputs 0. Partially written CSRs are not restored.

Decomposition:
- Shared defines package holds:
  - CSR addresses (0x300, 0x341, 0x342, 0x305);
  - the ECALL/EBREAK/MRET encodings;
  - sync cause codes;
  - state encodings (3-bit localparams).
- No sub-module. A single FSM plus output registers.

Test Plan:
- ecall at inst_addr_i=0x100, mstatus=0x8, mtvec=0x400:
  - hold_flag_o rises in the same cycle;
  - writes are mepc=0x100, then mstatus=0x80, then mcause=11;
  - then int_assert_o=1 with int_addr_o=0x400, and hold drops the next cycle.
- int_flag_i=0x01, global_int_en_i=1, jump_flag_i=1, jump_addr_i=0x220 -> mepc=0x220 and mcause=0x80000004. With global_int_en_i=0 there is no activity.
- mret with mstatus=0x80, mepc=0x104:
  - one write, mstatus=0x88;
  - then int_assert_o=1 with int_addr_o=0x104.
- ecall and int_flag_i asserted together -> only the SYNC sequence runs (cause 11). The interrupt is serviced after return to IDLE if still asserted and enabled.
- rst pulsed during W_MSTATUS -> the next cycle has all outputs 0, state IDLE, and no int_assert_o.
